// File: rtl/vc_wrr_if.sv
// Handshake bundle between the WRR scheduler, the per-class input FIFOs and the
// shared output FIFO. The scheduler side uses the master modport.
interface vc_wrr_if #(
  parameter int NCLASS = 4,
  parameter int WGT_W  = 3
);
  logic [NCLASS-1:0]       empty;
  logic [NCLASS-1:0]       almost_full;
  logic [NCLASS*WGT_W-1:0] weights;
  logic [NCLASS-1:0]       pop;
  logic                    push;
  logic [1:0]              grant_idx;
  logic                    busy;
  logic                    idle;

  modport master (
    input  empty, almost_full, weights,
    output pop, push, grant_idx, busy, idle
  );

  modport slave (
    output empty, almost_full, weights,
    input  pop, push, grant_idx, busy, idle
  );
endinterface

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin pop scheduler for the four per-class input FIFOs feeding
// the shared output FIFO; push trails pop by the 1-cycle FIFO read latency.
module vc_wrr_scheduler #(
  parameter int         NCLASS      = 4,
  parameter int         WGT_W       = 3,
  parameter logic [3:0] ACTIVE_CODE = 4'b0100
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [3:0] state,
  vc_wrr_if.master   bus
);
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PAUSE = 2'd2
  } st_e;

  st_e                          st_q, st_d;
  logic [IDX_W-1:0]             rr_q, rr_d;
  logic [IDX_W-1:0]             grant_q, grant_d;
  logic [WGT_W-1:0]             cnt_q, cnt_d;
  logic [WGT_W-1:0]             wgt_q, wgt_d;
  logic                         push_q, push_d;

  logic [NCLASS-1:0]            pop_c;
  logic [NCLASS-1:0]            req;
  logic [NCLASS-1:0][WGT_W-1:0] wgt_eff;
  logic                         ok;
  logic                         rot;
  logic                         ent_found, rot_found;
  logic [IDX_W-1:0]             ent_idx, rot_idx, rot_start;
  logic [WGT_W:0]               cnt_inc;

  // A zero weight would starve the class forever; serve it as weight 1.
  for (genvar g = 0; g < NCLASS; g++) begin : g_wgt
    logic [WGT_W-1:0] w_raw;
    assign w_raw      = bus.weights[g*WGT_W +: WGT_W];
    assign wgt_eff[g] = (w_raw == '0) ? WGT_W'(1) : w_raw;
  end

  // First requesting class at or after start, wrapping; lowest offset wins.
  function automatic logic [IDX_W:0] first_req(input logic [NCLASS-1:0] r,
                                               input logic [IDX_W-1:0]  start);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = NCLASS - 1; i >= 0; i--) begin
      idx = start + IDX_W'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign req       = ~bus.empty;
  assign ok        = (state == ACTIVE_CODE) && !(|bus.almost_full);
  assign rot_start = grant_q + IDX_W'(1);
  assign cnt_inc   = {1'b0, cnt_q} + (WGT_W+1)'(1);

  assign {ent_found, ent_idx} = first_req(req, rr_q);
  assign {rot_found, rot_idx} = first_req(req, rot_start);

  always_comb begin
    st_d    = st_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    wgt_d   = wgt_q;
    pop_c   = '0;
    rot     = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (ok && ent_found) begin
          st_d    = S_SERVE;
          grant_d = ent_idx;
          wgt_d   = wgt_eff[ent_idx];
          cnt_d   = '0;
        end
      end
      // A clean cycle in PAUSE serves straight away so a stall costs no extra bubble.
      S_SERVE, S_PAUSE: begin
        if (!ok) begin
          st_d = (st_q == S_PAUSE && !(|req)) ? S_IDLE : S_PAUSE;
        end else begin
          st_d = S_SERVE;
          if (bus.empty[grant_q]) begin
            rot = 1'b1;
          end else begin
            pop_c[grant_q] = 1'b1;
            if (cnt_inc >= {1'b0, wgt_q}) rot = 1'b1;
            else                          cnt_d = cnt_inc[WGT_W-1:0];
          end
        end
        if (rot) begin
          rr_d  = rot_start;
          cnt_d = '0;
          if (rot_found) begin
            grant_d = rot_idx;
            wgt_d   = wgt_eff[rot_idx];
          end else begin
            st_d = S_IDLE;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
    push_d = |pop_c;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st_q    <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      wgt_q   <= WGT_W'(1);
      push_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      wgt_q   <= wgt_d;
      push_q  <= push_d;
    end
  end

  assign bus.pop       = pop_c;
  assign bus.push      = push_q;
  assign bus.grant_idx = grant_q;
  assign bus.busy      = (st_q == S_SERVE);
  // Held high through reset regardless of the FIFO flags.
  assign bus.idle      = !reset_L || ((st_q == S_IDLE) && !push_q && (&bus.empty));
endmodule
